// File: rtl/seg_display_mux_if.sv
// seg_display_mux_if
//   Bundles the data-side and display-side signals of the 4-digit
//   seven-segment multiplexer.
//
//   Handshake: load is a single-cycle strobe with no back-pressure.
//   digits/dp_mask are sampled on any rising clk edge where load is 1.
//   The slave always accepts. The last strobe before a frame boundary wins.
//
//   Signals:
//     digits[15:0]  four BCD digits, [3:0] = rightmost digit 0
//     dp_mask[3:0]  decimal-point enables, bit i = digit i
//     load          capture strobe for digits/dp_mask
//     Seg[6:0]      cathodes {g,f,e,d,c,b,a}, active-low
//     decimal       decimal-point cathode, active-low
//     an[3:0]       digit anodes, active-low
//     frame_tick    one-cycle pulse on the first cycle of each frame
//     state         debug view of the slot FSM (0 = GUARD, 1 = DRIVE)
//   Modports: master drives digits/dp_mask/load, slave is the display mux.
interface seg_display_mux_if;
  logic [15:0] digits;
  logic [3:0]  dp_mask;
  logic        load;
  logic [6:0]  Seg;
  logic        decimal;
  logic [3:0]  an;
  logic        frame_tick;
  logic        state;

  modport master (
    output digits, dp_mask, load,
    input  Seg, decimal, an, frame_tick, state
  );

  modport slave (
    input  digits, dp_mask, load,
    output Seg, decimal, an, frame_tick, state
  );
endinterface

// File: rtl/seg_display_mux.sv
// seg_display_mux
//   Time-multiplexes four BCD digits onto one seven-segment display.
//   Each digit owns a slot of REFRESH_DIV clocks. The first BLANK_CYCLES
//   clocks of every slot are a blank guard interval that suppresses ghosting.
//   New digit values are staged in a pending register. They reach the display
//   only at a frame boundary, so a frame never mixes old and new values.
//
//   Parameters:
//     REFRESH_DIV   clocks per digit slot (4 .. 2^20)
//     BLANK_CYCLES  guard clocks at the start of each slot (1 .. REFRESH_DIV-2)
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous active-low reset
//     bus    seg_display_mux_if.slave (digits, dp_mask, load in;
//            Seg, decimal, an, frame_tick, state out)
//   Optional feature:
//     LEADING_ZERO_BLANK_EN  when defined, leading zero digits 3..1 are
//                            blanked. A digit's decimal point keeps that
//                            digit visible.
module seg_display_mux #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input logic              clk,
  input logic              reset,
  seg_display_mux_if.slave bus
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [0:0] GUARD = 1'b0;
  localparam logic [0:0] DRIVE = 1'b1;

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [15:0]   r_pend_digits;
  logic [3:0]    r_pend_dp;
  logic [15:0]   r_disp_digits;
  logic [3:0]    r_disp_dp;
  logic [0:0]    r_state;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic          r_tick;

  logic          w_cnt_end;
  logic          w_wrap;
  logic [CW-1:0] w_cnt_nxt;
  logic [1:0]    w_idx_nxt;
  logic [15:0]   w_disp_digits_nxt;
  logic [3:0]    w_disp_dp_nxt;
  logic [0:0]    w_state_nxt;
  logic [3:0]    w_digit;
  logic          w_dp_en;
  logic [3:0]    w_visible;
  logic          w_drive;
  logic [6:0]    w_dec;

  assign w_cnt_end = (r_cnt == CW'(REFRESH_DIV - 1));
  assign w_wrap    = w_cnt_end && (r_idx == 2'd3);
  assign w_cnt_nxt = w_cnt_end ? '0 : r_cnt + 1'b1;
  assign w_idx_nxt = w_cnt_end ? r_idx + 2'd1 : r_idx;

  // A load on the wrap cycle bypasses pending and lands in the new frame.
  always_comb begin
    w_disp_digits_nxt = r_disp_digits;
    w_disp_dp_nxt     = r_disp_dp;
    if (w_wrap) begin
      w_disp_digits_nxt = bus.load ? bus.digits  : r_pend_digits;
      w_disp_dp_nxt     = bus.load ? bus.dp_mask : r_pend_dp;
    end
  end

  // Outputs are registered from next-cycle values so they line up with
  // the counter they were derived from.
  assign w_state_nxt = (w_cnt_nxt < CW'(BLANK_CYCLES)) ? GUARD : DRIVE;
  assign w_digit     = w_disp_digits_nxt[{w_idx_nxt, 2'b00} +: 4];
  assign w_dp_en     = w_disp_dp_nxt[w_idx_nxt];

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is visible if it is non-zero, has its point lit, or any more
  // significant digit is visible. Digit 0 is always shown.
  always_comb begin
    w_visible[3] = (w_disp_digits_nxt[15:12] != 4'd0) || w_disp_dp_nxt[3];
    w_visible[2] = w_visible[3] || (w_disp_digits_nxt[11:8] != 4'd0) || w_disp_dp_nxt[2];
    w_visible[1] = w_visible[2] || (w_disp_digits_nxt[7:4] != 4'd0) || w_disp_dp_nxt[1];
    w_visible[0] = 1'b1;
  end
`else
  assign w_visible = 4'b1111;
`endif

  assign w_drive = (w_state_nxt == DRIVE) && w_visible[w_idx_nxt];

  always_comb begin
    case (w_digit)
      4'd0:    w_dec = 7'b1000000;
      4'd1:    w_dec = 7'b1111001;
      4'd2:    w_dec = 7'b0100100;
      4'd3:    w_dec = 7'b0110000;
      4'd4:    w_dec = 7'b0011001;
      4'd5:    w_dec = 7'b0010010;
      4'd6:    w_dec = 7'b0000010;
      4'd7:    w_dec = 7'b1111000;
      4'd8:    w_dec = 7'b0000000;
      4'd9:    w_dec = 7'b0010000;
      default: w_dec = 7'b0111111; // non-BCD codes show a dash
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt         <= '0;
      r_idx         <= 2'd0;
      r_pend_digits <= 16'h0000;
      r_pend_dp     <= 4'h0;
      r_disp_digits <= 16'h0000;
      r_disp_dp     <= 4'h0;
      r_state       <= GUARD;
      r_an          <= 4'b1111;
      r_seg         <= 7'h7F;
      r_dp          <= 1'b1;
      r_tick        <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_idx <= w_idx_nxt;
      if (bus.load) begin
        r_pend_digits <= bus.digits;
        r_pend_dp     <= bus.dp_mask;
      end
      r_disp_digits <= w_disp_digits_nxt;
      r_disp_dp     <= w_disp_dp_nxt;
      r_state       <= w_state_nxt;
      r_an          <= w_drive ? ~(4'b0001 << w_idx_nxt) : 4'b1111;
      r_seg         <= w_drive ? w_dec : 7'h7F;
      r_dp          <= w_drive ? ~w_dp_en : 1'b1;
      r_tick        <= w_wrap;
    end
  end

  assign bus.an         = r_an;
  assign bus.Seg        = r_seg;
  assign bus.decimal    = r_dp;
  assign bus.frame_tick = r_tick;
  assign bus.state      = r_state;

endmodule

// File: doc/seg_display_mux.md
SEG_DISPLAY_MUX -- requirements
Module: seg_display_mux

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000: clk cycles per digit slot (1 kHz per digit at 100 MHz); legal range 4..2^20.
REQ-002 SHALL have parameter BLANK_CYCLES, default 1000: anti-ghost guard cycles at the start of each slot; legal range 1..REFRESH_DIV-2.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; assertion clears all state immediately, deassertion is synchronous to clk.
REQ-005 digits  input  16  four BCD digits from the stopwatch; [3:0] = digit 0 (rightmost) ... [15:12] = digit 3.
REQ-006 dp_mask  input  4  decimal-point enables, bit i = digit i.
REQ-007 load  input  1  single-cycle strobe; digits and dp_mask are valid when high.
REQ-008 Seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
REQ-009 decimal  output  1  decimal-point cathode, active-low.
REQ-010 an  output  4  digit anodes, active-low, one-hot-low or all-high.
REQ-011 frame_tick  output  1  one-cycle pulse at each frame start (slot 0 entered).

Function
REQ-012 Slot counter SHALL count 0..REFRESH_DIV-1 and wrap; on wrap, 2-bit digit index SHALL advance 0->1->2->3->0.
REQ-013 FSM states GUARD, DRIVE per slot: GUARD while slot counter < BLANK_CYCLES, DRIVE otherwise; no other states.
REQ-014 GUARD: an = 4'b1111, Seg = 7'h7F, decimal = 1.
REQ-015 DRIVE: an bit[index] = 0, others 1; Seg = decode of display digit[index]; decimal = ~dp[index].
REQ-016 Decode: 0..9 standard patterns (e.g. 0 -> 7'b1000000, 8 -> 7'b0000000); codes 10..15 SHALL show dash, Seg = 7'b0111111.
REQ-017 load SHALL capture digits/dp_mask into a pending register; pending SHALL transfer to the display register only on the cycle the index wraps 3->0 (tear-free frames).
REQ-018 load coincident with the wrap cycle SHALL bypass: the newly loaded value becomes the display value for the frame that starts.
REQ-019 Multiple loads within one frame: last one wins; no load: display value held indefinitely.
REQ-020 frame_tick SHALL pulse in the cycle after the 3->0 wrap, aligned with the first GUARD cycle of slot 0.
REQ-021 Outputs SHALL be registered (no combinational path from digits/load to Seg/an); display latency from wrap to first driven digit = BLANK_CYCLES+1 clocks.

Reset
REQ-022 On reset assertion: slot counter 0, index 0, state GUARD, pending and display registers 16'h0000/4'h0, an = 4'b1111, Seg = 7'h7F, decimal = 1, frame_tick = 0.
REQ-023 Reset asserted mid-slot or mid-DRIVE SHALL blank anodes the same instant (asynchronous) and restart at slot 0 GUARD after release; no frame_tick for the restarted frame.

Configuration
REQ-024 Macro LEADING_ZERO_BLANK_EN: when defined, digits 3, 2, 1 showing BCD 0 with all more-significant digits also 0 SHALL be blanked (an held high in DRIVE for that slot), digit 0 always shown; decimal-point enable of a digit SHALL defeat its blanking.
REQ-025 Without LEADING_ZERO_BLANK_EN, all four digits SHALL always be driven, zeros included.

Verification (bench: REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-026 Release reset, no load -> an cycles 1110,1101,1011,0111 each for 6 clocks after 2 guard clocks of 1111; Seg = 7'b1000000 in every DRIVE; frame_tick every 32 clocks.
REQ-027 load digits=16'h1234, dp_mask=4'b0100 mid-frame -> unchanged until next wrap; then digit2 shows 2 (7'b0100100) with decimal=0, others decimal=1.
REQ-028 Two loads 16'h1111 then 16'h5678 in one frame -> next frame shows 5678 only; load on wrap cycle with 16'h9999 -> that frame shows 9999.
REQ-029 digits=16'hA0F9 -> digits 3,1 show dash 7'b0111111, digit 0 shows 9, digit 2 shows 0.
REQ-030 Reset pulse during DRIVE of slot 2 -> an=1111 immediately, Seg=7'h7F; after release restarts at slot 0 GUARD with display 0000.
REQ-031 With LEADING_ZERO_BLANK_EN, digits=16'h0050, dp_mask=4'b1000 -> digit3 driven (0 with dp), digit2 driven (0, not leading since digit3 visible), digits 1,0 show 5,0; without dp_mask, digit3 and digit2 blanked.
